// File: rtl/exp_sum_collector.sv
// Collects one softmax vector of exp values, accumulates their sum, then
// replays the buffered values with the final sum over a valid/ready handshake.
module exp_sum_collector #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10,
    parameter int sum_size       = 36
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 data_valid_i,
    input  logic [data_size-1:0] data_i,
    input  logic                 ready_i,
    output logic                 data_valid_o,
    output logic [data_size-1:0] data_o,
    output logic [sum_size-1:0]  sum_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    localparam int CW = (number_of_data > 1) ? $clog2(number_of_data) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(number_of_data - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_REPLAY  = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CW-1:0]        r_wr_cnt;
    logic [CW-1:0]        r_rd_cnt;
    logic [CW-1:0]        w_rd_next;
    logic [sum_size-1:0]  r_acc;
    logic [sum_size-1:0]  w_acc_sum;
    logic [data_size-1:0] r_buffer [number_of_data];
    logic [data_size-1:0] w_data_d;

    logic                 r_data_valid;
    logic [data_size-1:0] r_data;
    logic [sum_size-1:0]  r_sum;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overflow;

    logic                 w_in_take;
    logic                 w_last_in;
    logic                 w_beat_xfer;
    logic                 w_dv_d;
    logic                 w_busy_d;
    logic                 w_last_d;
    logic                 w_done_d;

    assign w_in_take   = data_valid_i && (r_state == S_COLLECT);
    assign w_last_in   = w_in_take && (r_wr_cnt == LAST_IDX);
    assign w_beat_xfer = r_data_valid && ready_i;
    assign w_acc_sum   = r_acc + {{(sum_size - data_size){1'b0}}, data_i};
    // Read address is looked ahead so the next beat is already registered at transfer
    assign w_data_d    = r_buffer[w_rd_next];

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: begin
                if (w_last_in) begin
                    w_next_state = S_REPLAY;
                end else begin
                    w_next_state = S_COLLECT;
                end
            end
            S_REPLAY: begin
                if (w_beat_xfer && r_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_REPLAY;
                end
            end
            S_DONE:  w_next_state = S_COLLECT;
            default: w_next_state = S_COLLECT;
        endcase
    end

    // Output decode: next read index and the values the output registers take
    always_comb begin
        w_rd_next = r_rd_cnt;
        w_dv_d    = 1'b0;
        w_busy_d  = 1'b0;
        w_last_d  = 1'b0;
        w_done_d  = 1'b0;
        if ((r_state == S_REPLAY) && w_beat_xfer) begin
            if (r_rd_cnt == LAST_IDX) begin
                w_rd_next = {CW{1'b0}};
            end else begin
                w_rd_next = r_rd_cnt + CW'(1);
            end
        end else begin
            w_rd_next = r_rd_cnt;
        end
        case (w_next_state)
            S_REPLAY: begin
                w_dv_d   = 1'b1;
                w_busy_d = 1'b1;
                w_last_d = (w_rd_next == LAST_IDX);
            end
            S_DONE:  w_done_d = 1'b1;
            default: w_dv_d   = 1'b0;
        endcase
    end

    // Counters and accumulator
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_wr_cnt <= {CW{1'b0}};
            r_rd_cnt <= {CW{1'b0}};
            r_acc    <= {sum_size{1'b0}};
        end else begin
            r_rd_cnt <= w_rd_next;
            if (w_last_in) begin
                r_wr_cnt <= {CW{1'b0}};
            end else if (w_in_take) begin
                r_wr_cnt <= r_wr_cnt + CW'(1);
            end
            if (r_state == S_DONE) begin
                r_acc <= {sum_size{1'b0}};
            end else if (w_in_take) begin
                r_acc <= w_acc_sum;
            end
        end
    end

    // Vector storage; contents are don't-care after reset
    always_ff @(posedge clock_i) begin
        if (w_in_take) begin
            r_buffer[r_wr_cnt] <= data_i;
        end
    end

    // Registered outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_data_valid <= 1'b0;
            r_data       <= {data_size{1'b0}};
            r_sum        <= {sum_size{1'b0}};
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_data_valid <= w_dv_d;
            r_busy       <= w_busy_d;
            r_last       <= w_last_d;
            r_done       <= w_done_d;
            if (w_dv_d) begin
                r_data <= w_data_d;
            end
            if (w_last_in) begin
                r_sum <= w_acc_sum;
            end
            if (data_valid_i && (r_state != S_COLLECT)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign data_valid_o = r_data_valid;
    assign data_o       = r_data;
    assign sum_o        = r_sum;
    assign last_o       = r_last;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_exp_sum_collector.sv
// Randomized scoreboard bench for exp_sum_collector: the stimulus side pushes
// expected replay beats, an independent monitor pops and compares them.
module tb_exp_sum_collector;

    localparam int DW = 32;
    localparam int N  = 10;
    localparam int SW = 36;

    typedef logic [DW-1:0] vec_t [N];
    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [SW-1:0] s;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          data_valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          ready_i = 1'b1;
    logic          data_valid_o;
    logic [DW-1:0] data_o;
    logic [SW-1:0] sum_o;
    logic          last_o;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;

    int            tests = 0;
    int            fails = 0;
    int            ready_mode = 0;
    logic          exp_overflow = 1'b0;
    logic [SW-1:0] last_sum = '0;
    logic          prev_last_xfer = 1'b0;
    beat_t         sb[$];

    exp_sum_collector #(.data_size(DW), .number_of_data(N), .sum_size(SW)) dut (
        .clock_i     (clk),
        .reset_i     (reset_i),
        .data_valid_i(data_valid_i),
        .data_i      (data_i),
        .ready_i     (ready_i),
        .data_valid_o(data_valid_o),
        .data_o      (data_o),
        .sum_o       (sum_o),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Downstream ready generator: always, 1-0-0 pattern, or random
    initial begin
        int pat;
        pat = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = (pat % 3 == 0);
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
            pat++;
        end
    end

    // Monitor: compares every presented beat against the scoreboard head
    always @(negedge clk) begin
        logic  nxt;
        beat_t e;
        nxt = 1'b0;
        if (reset_i) begin
            prev_last_xfer = 1'b0;
        end else begin
            chk("done_pulse", done_o, prev_last_xfer);
            chk("overflow", overflow_o, exp_overflow);
            if (prev_last_xfer) begin
                chk("valid_in_done", data_valid_o, 1'b0);
                chk("busy_in_done", busy_o, 1'b0);
            end
            if (data_valid_o) begin
                chk("beat_expected", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    chk("beat_data", data_o, e.d);
                    chk("beat_last", last_o, e.l);
                    chk("beat_sum", sum_o, e.s);
                    chk("beat_busy", busy_o, 1'b1);
                    if (ready_i) begin
                        void'(sb.pop_front());
                        nxt = e.l;
                    end
                end
            end
            prev_last_xfer = nxt;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_i      = 1'b1;
        data_valid_i = 1'b0;
        data_i       = '0;
        @(posedge clk);
        #1;
        reset_i      = 1'b0;
        sb.delete();
        exp_overflow = 1'b0;
        last_sum     = '0;
        chk("rst_valid", data_valid_o, 1'b0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_sum", sum_o, 36'd0);
        chk("rst_last", last_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_overflow", overflow_o, 1'b0);
    endtask

    // Drives a full vector with 'gap' idle cycles between values and
    // queues the expected replay once the vector is complete
    task automatic send_vector(input vec_t vals, input int gap);
        longint unsigned acc;
        logic [SW-1:0]   es;
        beat_t           b;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            #1;
            chk("sum_hold", sum_o, last_sum);
            data_valid_i = 1'b1;
            data_i       = vals[i];
            acc          = acc + longint'(vals[i]);
            if (i < N - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                    data_valid_i = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;
        es = acc[SW-1:0];
        for (int i = 0; i < N; i++) begin
            b.d = vals[i];
            b.l = (i == N - 1);
            b.s = es;
            sb.push_back(b);
        end
        chk("first_beat_latency", data_valid_o, 1'b1);
        chk("sum_at_first_beat", sum_o, es);
        last_sum = es;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (done_o) break;
        end
        if (n >= 300) chk("done_timeout", 1'b0, 1'b1);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        vec_t v;
        int   n;

        do_reset();

        // 1..10, ready always high
        ready_mode = 0;
        for (int i = 0; i < N; i++) v[i] = DW'(i + 1);
        send_vector(v, 0);
        chk("sum_55", sum_o, 36'h37);
        wait_done(n);
        chk("b2b_replay_cycles", n, 11);

        // all-ones maximum values
        for (int i = 0; i < N; i++) v[i] = 32'hFFFF_FFFF;
        send_vector(v, 0);
        chk("sum_max", sum_o, 36'h9_FFFF_FFF6);
        wait_done(n);

        // 5,0,7,random with 2-cycle gaps, ready toggling 1,0,0
        ready_mode = 1;
        v[0] = 32'd5;
        v[1] = 32'd0;
        v[2] = 32'd7;
        for (int i = 3; i < N; i++) v[i] = $urandom;
        send_vector(v, 2);
        wait_done(n);

        // back-to-back vectors: 1..10 then ten 100s
        ready_mode = 0;
        for (int i = 0; i < N; i++) v[i] = DW'(i + 1);
        send_vector(v, 0);
        wait_done(n);
        for (int i = 0; i < N; i++) v[i] = 32'd100;
        send_vector(v, 0);
        chk("sum_1000", sum_o, 36'd1000);
        wait_done(n);

        // input injected during replay is dropped and flags overflow
        ready_mode = 2;
        for (int i = 0; i < N; i++) v[i] = $urandom;
        send_vector(v, 0);
        data_valid_i = 1'b1;
        data_i       = 32'h1234;
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;
        exp_overflow = 1'b1;
        wait_done(n);
        for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 1000);
        send_vector(v, 1);
        wait_done(n);
        chk("overflow_sticky", overflow_o, 1'b1);

        // reset mid-collect, then ten 2s
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            data_valid_i = 1'b1;
            data_i       = $urandom;
        end
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < N; i++) v[i] = 32'd2;
        send_vector(v, 0);
        chk("sum_20", sum_o, 36'd20);
        wait_done(n);

        // random vectors with random gaps and random ready
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) v[i] = $urandom;
            send_vector(v, int'($urandom_range(0, 2)));
            wait_done(n);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exp_sum_collector.md
Name: exp_sum_collector

Overview:
- Receiver for the exp-stage output stream (`data_valid_o`/`data_o` of the downscale/exp stage) in the softmax datapath.
- Captures one vector of `number_of_data` exp values into a local buffer and accumulates their full-precision sum.
- Once the vector is complete, replays the buffered values with the final sum to the normalisation/divide stage, using a valid/ready handshake.

Parameters:
- `data_size`, 32, width of each exp value (unsigned).
- `number_of_data`, 10, number of values per softmax vector (N ≥ 2).
- `sum_size`, 36, accumulator width; must be ≥ `data_size` + ceil(log2(`number_of_data`)).

Ports:
- `clock_i`  input  1  single clock; all logic on its rising edge.
- `reset_i`  input  1  synchronous, active-high reset.
- `data_valid_i`  input  1  exp value present on `data_i` this cycle; no backpressure toward the source.
- `data_i`  input  `data_size`  unsigned exp value.
- `ready_i`  input  1  downstream accepts the current replay beat.
- `data_valid_o`  output  1  replay beat valid.
- `data_o`  output  `data_size`  buffered exp value being replayed.
- `sum_o`  output  `sum_size`  sum of all N values of the current vector.
- `last_o`  output  1  high with the N-th replay beat.
- `busy_o`  output  1  high in REPLAY state.
- `done_o`  output  1  one-cycle pulse after the last beat is accepted.
- `overflow_o`  output  1  sticky; a value arrived while not in COLLECT.

Behaviour:
- Reset (`reset_i`=1 at a clock edge), from any state including mid-collect or mid-replay:
  - state goes to COLLECT; write and read counters go to 0; accumulator goes to 0.
  - all outputs go to 0: `data_valid_o`, `data_o`, `sum_o`, `last_o`, `busy_o`, `done_o`, `overflow_o`.
  - buffer contents need not be cleared.
- State machine: COLLECT → REPLAY → DONE → COLLECT.
- COLLECT:
  - On each cycle with `data_valid_i`=1: `buffer[wr_cnt]` ← `data_i`; `acc` ← `acc` + zero-extended `data_i`; `wr_cnt` increments.
  - Gaps (`data_valid_i`=0) are allowed and hold all state.
  - When a valid arrives with `wr_cnt`=N-1:
    - the value is stored and added;
    - `sum_o` ← final `acc` (including this value);
    - `wr_cnt` ← 0; next state is REPLAY.
  - `sum_o` holds its previous value until then.
- REPLAY:
  - `data_valid_o`=1, `busy_o`=1, `data_o`=`buffer[rd_cnt]`, `last_o`=(`rd_cnt`==N-1).
  - Outputs are registered so `data_o` is stable while `ready_i`=0. The first beat is valid in the cycle after the N-th input was captured (latency 1 from the last input).
  - A beat transfers on `data_valid_o` && `ready_i`; `rd_cnt` advances and the next value presents in the following cycle.
  - With `ready_i` held high, the replay is N back-to-back cycles.
  - On transfer of the last beat: `rd_cnt` ← 0; next state is DONE.
  - `sum_o` is constant throughout REPLAY.
- DONE (one cycle):
  - `done_o`=1, `data_valid_o`=0, `busy_o`=0; `acc` cleared; next state is COLLECT.
  - `sum_o` keeps the last sum until the next vector completes.
- Input outside COLLECT: a `data_valid_i`=1 in REPLAY or DONE is dropped (not written, not summed) and sets `overflow_o`=1. `overflow_o` is cleared only by reset.
- Arithmetic:
  - Unsigned, no saturation; `sum_size` guarantees no wrap for N maximal inputs.
  - Accumulator addition is a single-cycle adder.
- The buffer is N × `data_size` registers (or inferred RAM with registered read); read-address prefetch must keep the back-to-back rate.

Test Plan:
- N=10, inputs 1..10 back-to-back, `ready_i`=1 → one cycle after the 10th input `sum_o`=55 (0x37); replay beats 1..10 on consecutive cycles; `last_o` only on value 10; `done_o` pulses the cycle after; `overflow_o`=0.
- N=10, each input 0xFFFFFFFF → `sum_o`=0x9_FFFF_FFF6; every replay beat `data_o`=0xFFFFFFFF.
- Inputs 5,0,7,… with 2-cycle `data_valid_i` gaps; during replay `ready_i` toggles 1,0,0,1,… → stored order preserved; `data_o` and `last_o` hold while `ready_i`=0; exactly 10 transfers; `sum_o` matches the reference-model sum.
- Two consecutive vectors (1..10, then 10×100) → second `sum_o`=1000, with no carry-over from the first (acc cleared in DONE).
- `data_valid_i`=1 with value 0x1234 during REPLAY → value absent from the replay and from the next sum; `overflow_o`=1 until reset.
- Reset asserted after 4 of 10 inputs, then 10 fresh inputs of 2 → `sum_o`=20; all outputs 0 in the cycle after reset; replay shows ten 2s.
